// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with a valid/ready handshake and tag sideband.
// Optional macro PREFIX_ADDER_SAT_EN enables signed saturation on overflow when sat_i is set.
`default_nettype none

module prefix_adder_pipe #(
   parameter int WIDTH            = 32,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int TAG_W            = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               cin_i,
   input  logic               sub_i,
   input  logic               sat_i,
   input  logic [TAG_W-1:0]   tag_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   s_o,
   output logic               cout_o,
   output logic               ovf_o,
   output logic               zero_o,
   output logic [TAG_W-1:0]   tag_o
);

   localparam int LOG = $clog2(WIDTH);
   localparam int N2  = 1 << LOG;
   localparam int NS  = (LOG + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

   logic [N2-1:0]    r_g   [0:NS-1];
   logic [N2-1:0]    r_p   [0:NS-1];
   logic [WIDTH-1:0] r_x   [0:NS-1];
   logic [TAG_W-1:0] r_tag [0:NS-1];
   logic [NS-1:0]    r_c0;
   logic [NS:0]      r_v;
   logic             r_live;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic [TAG_W-1:0] r_otag;
`ifdef PREFIX_ADDER_SAT_EN
   logic [NS-1:0]    r_sat;
   logic [NS-1:0]    r_amsb;
`endif

   logic [WIDTH-1:0] w_bp;
   logic             w_c0;
   logic [N2-1:0]    w_g0;
   logic [N2-1:0]    w_p0;
   logic [N2-1:0]    w_gt [0:NS-1];
   logic [N2-1:0]    w_pt [0:NS-1];
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic [NS:0]      w_ld;

   assign w_bp = sub_i ? ~b_i : b_i;
   assign w_c0 = sub_i | cin_i;
   // Lanes above WIDTH are zero-padded so they never generate or propagate.
   assign w_g0 = N2'(a_i & w_bp);
   assign w_p0 = N2'(a_i | w_bp);

   // Each pipeline stage k evaluates tree levels k*LPS .. (k+1)*LPS-1.
   always_comb begin
      logic [N2-1:0] g, p, gn, pn;
      g  = '0;
      p  = '0;
      gn = '0;
      pn = '0;
      for (int k = 0; k < NS; k++) begin
         g = r_g[k];
         p = r_p[k];
         for (int l = 0; l < LOG; l++) begin
            if (l / LEVELS_PER_STAGE == k) begin
               gn = g;
               pn = p;
               for (int i = (1 << l); i < N2; i++) begin
                  gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                  pn[i] = p[i] & p[i - (1 << l)];
               end
               g = gn;
               p = pn;
            end
         end
         w_gt[k] = g;
         w_pt[k] = p;
      end
   end

   // Group (G,P) over [i-1:0] plus the carry-in acting as a bit -1 generate.
   always_comb begin
      w_c    = '0;
      w_c[0] = r_c0[NS-1];
      for (int i = 1; i <= WIDTH; i++) begin
         w_c[i] = w_gt[NS-1][i-1] | (w_pt[NS-1][i-1] & r_c0[NS-1]);
      end
   end

   assign w_sum = r_x[NS-1] ^ w_c[WIDTH-1:0];
   assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

`ifdef PREFIX_ADDER_SAT_EN
   always_comb begin
      w_res = w_sum;
      if (r_sat[NS-1] && w_ovf) begin
         w_res = r_amsb[NS-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign w_res = w_sum;
   logic w_unused_sat;
   assign w_unused_sat = sat_i;
`endif

   generate
      if (N2 > WIDTH) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^{w_gt[NS-1][N2-1:WIDTH], w_pt[NS-1][N2-1:WIDTH]};
      end
   endgenerate

   // A stage may load when empty or when its content moves on this cycle.
   always_comb begin
      logic [NS:0] ld;
      ld     = '0;
      ld[NS] = !r_v[NS] || out_ready;
      for (int k = NS - 1; k >= 0; k--) begin
         ld[k] = !r_v[k] || ld[k+1];
      end
      w_ld = ld;
   end

   assign in_ready  = r_live & w_ld[0] & ~reset;
   assign out_valid = r_v[NS];
   assign s_o       = r_s;
   assign cout_o    = r_cout;
   assign ovf_o     = r_ovf;
   assign zero_o    = r_zero;
   assign tag_o     = r_otag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v    <= '0;
         r_live <= 1'b0;
         r_c0   <= '0;
         r_s    <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         r_otag <= '0;
`ifdef PREFIX_ADDER_SAT_EN
         r_sat  <= '0;
         r_amsb <= '0;
`endif
         for (int k = 0; k < NS; k++) begin
            r_g[k]   <= '0;
            r_p[k]   <= '0;
            r_x[k]   <= '0;
            r_tag[k] <= '0;
         end
      end else begin
         r_live <= 1'b1;
         if (w_ld[0]) begin
            r_v[0]   <= in_valid & in_ready;
            r_g[0]   <= w_g0;
            r_p[0]   <= w_p0;
            r_x[0]   <= a_i ^ w_bp;
            r_c0[0]  <= w_c0;
            r_tag[0] <= tag_i;
`ifdef PREFIX_ADDER_SAT_EN
            r_sat[0]  <= sat_i;
            r_amsb[0] <= a_i[WIDTH-1];
`endif
         end
         for (int k = 1; k < NS; k++) begin
            if (w_ld[k]) begin
               r_v[k]   <= r_v[k-1];
               r_g[k]   <= w_gt[k-1];
               r_p[k]   <= w_pt[k-1];
               r_x[k]   <= r_x[k-1];
               r_c0[k]  <= r_c0[k-1];
               r_tag[k] <= r_tag[k-1];
`ifdef PREFIX_ADDER_SAT_EN
               r_sat[k]  <= r_sat[k-1];
               r_amsb[k] <= r_amsb[k-1];
`endif
            end
         end
         if (w_ld[NS]) begin
            r_v[NS] <= r_v[NS-1];
            r_s     <= w_res;
            r_cout  <= w_c[WIDTH];
            r_ovf   <= w_ovf;
            r_zero  <= (w_res == '0);
            r_otag  <= r_tag[NS-1];
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined parallel-prefix adder/subtractor. Next generation of the team's 32-bit combinational prefix adder.
- Generalised in width, with a configurable number of prefix levels between registers, add/subtract mode, signed/unsigned flags and a tag sideband.
- Valid/ready handshake on input and output, so it drops into streaming datapaths (ALU back-end, accumulator feed) with full back-pressure.

Parameters:
- WIDTH, 32: operand width in bits; any value ≥ 2.
- LEVELS_PER_STAGE, 2: prefix-tree levels (black-box rows) evaluated between pipeline registers; ≥ 1.
- TAG_W, 4: width of the tag carried alongside each operation; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- cin_i  in  1  carry-in (add mode only).
- sub_i  in  1  1 = A − B, 0 = A + B + cin.
- sat_i  in  1  request signed saturation (see Optional Feature).
- tag_i  in  TAG_W  user tag, returned unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- s_o  out  WIDTH  sum/difference.
- cout_o  out  1  carry-out of MSB (for SUB: 1 = no borrow).
- ovf_o  out  1  signed overflow.
- zero_o  out  1  s_o == 0.
- tag_o  out  TAG_W  tag of this result.

Behaviour:
- Datapath:
  - Operand prep: b' = sub_i ? ~b_i : b_i; c0 = sub_i ? 1 : cin_i.
  - Per bit: p = a|b', g = a&b' (same propagate convention as the existing adder). c0 is folded in as the bit −1 generate.
  - Kogge-Stone prefix tree of LOG = ceil(log2(WIDTH)) levels. Black-box op: G = Gl | (Pl & Gr), P = Pl & Pr.
  - Sum: s = a ^ b' ^ carry. cout = carry into bit WIDTH. ovf = carry into MSB XOR carry out of MSB.
- Pipeline:
  - Stage 0 registers the prepared operands, c0, sub, sat and tag.
  - Then NS = ceil(LOG / LEVELS_PER_STAGE) stages. The last stage also computes sum and flags and holds the output register.
  - Latency from an accepted input to out_valid = 1 + NS cycles. Default WIDTH=32, LPS=2 gives 4.
  - Throughput is 1 beat/cycle when out_ready = 1.
- Handshake:
  - Each stage has a valid bit. A stage loads when it is empty or its content is moving forward that cycle (bubble-collapsing).
  - in_ready = !v0 || stage0 advances. in_ready is combinational from out_ready through the valid chain; this chain is not registered.
  - A beat is accepted on in_valid & in_ready. A result is consumed on out_valid & out_ready.
  - While out_valid & !out_ready, s_o, flags and tag_o hold stable.
  - Simultaneous accept and consume with a full pipeline is allowed, and no beat is lost.
  - Inputs are ignored when in_valid = 0.
- Reset:
  - Reset is asynchronous: all valid bits, s_o, cout_o, ovf_o, zero_o and tag_o clear to 0 immediately. zero_o resets to 0, not 1.
  - in_ready is forced 0 while reset is high and returns to 1 on the first clock after release.
  - Reset mid-operation discards all in-flight beats. No partial result is emitted.
- Width edge cases:
  - WIDTH not a power of 2: the tree is built for the next power of 2 with unused lanes tied to p=0, g=0. Outputs are truncated to WIDTH.
  - If LEVELS_PER_STAGE ≥ LOG, NS = 1 (latency 2).

Optional Feature:
- Macro PREFIX_ADDER_SAT_EN.
- Defined: when sat_i = 1 and signed overflow occurs, s_o = A[MSB] ? 1 followed by WIDTH−1 zeros (most negative) : 0 followed by WIDTH−1 ones (most positive). ovf_o is still 1, and zero_o is computed on the saturated value. The clamp adds no extra cycle.
- Not defined: sat_i is ignored (no logic is generated) and s_o is always the wrapped result.

Test Plan:
- Add, WIDTH 32: a=0xFFFFFFFF, b=0x00000001, cin=0 → s=0x00000000, cout=1, ovf=0, zero=1, out_valid exactly 4 cycles after accept.
- Subtract: a=0x00000005, b=0x00000007 → s=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=0x00000001 → s=0x7FFFFFFF, ovf=1. With PREFIX_ADDER_SAT_EN and sat_i=1, the second case gives s=0x80000000, ovf=1.
- Back-pressure: stream 8 beats with tags 0..7, hold out_ready=0 for 6 cycles → in_ready drops after the pipeline fills. Release → tags emerge 0..7 in order, no loss or duplication, outputs stable while stalled.
- Reset mid-flight: accept 3 beats, assert reset asynchronously between clock edges → out_valid=0 immediately. After release, no stale result appears; a new beat returns a correct result 4 cycles after accept.
- Parameter sweep: WIDTH ∈ {8, 13, 64}, LPS ∈ {1, 3, 8}, 10k random beats with random valid/ready → all results match a behavioural model; latency equals 1 + ceil(ceil(log2 WIDTH)/LPS).
